key_scan_encoder: RTL and testbench



---
 rtl/key_scan_encoder_if.sv | 21 ++
 rtl/key_scan_encoder.sv | 169 ++++++++++++++++
 tb/tb_key_scan_encoder.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/key_scan_encoder_if.sv
// Raw switch rows in, debounced key events and buzzer drive out.
interface key_scan_encoder_if;
    logic [4:0] input_row1;
    logic [4:0] input_row2;
    logic [4:0] input_row3;
    logic [4:0] input_row4;
    logic       key_valid;
    logic [4:0] key_code;
    logic       key_held;
    logic       beep;

    modport master (
        output input_row1, input_row2, input_row3, input_row4,
        input  key_valid, key_code, key_held, beep
    );

    modport slave (
        input  input_row1, input_row2, input_row3, input_row4,
        output key_valid, key_code, key_held, beep
    );
endinterface

// File: rtl/key_scan_encoder.sv
// Synchronizes and debounces the 20 active-low switch lines, encodes the 18 mapped
// keys into single-cycle key events and drives the key-click buzzer.
module key_scan_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 8,
    parameter int unsigned CNT_W           = 4,
    parameter int unsigned BEEP_CYCLES     = 16
) (
    input  logic                sys_clk,
    input  logic                rst_n,
    key_scan_encoder_if.slave   bus
);

    localparam int unsigned N_LINES = 20;
    localparam int unsigned N_KEYS  = 18;
    localparam int unsigned CODE_W  = 5;
    localparam int unsigned BEEP_W  = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } state_e;

    logic [N_LINES-1:0] raw;
    logic [N_LINES-1:0] sync1_q;
    logic [N_LINES-1:0] sync2_q;
    logic [N_LINES-1:0] pressed;
    logic [N_KEYS-1:0]  hot;
    logic               single;
    logic               none;
    logic [CODE_W-1:0]  cur;
    logic               unused_rows;

    state_e             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [CODE_W-1:0]  cand_q,      cand_d;
    logic               key_valid_q, key_valid_d;
    logic [CODE_W-1:0]  key_code_q,  key_code_d;
    logic               key_held_q,  key_held_d;
    logic               beep_q,      beep_d;
    logic [BEEP_W-1:0]  beep_cnt_q,  beep_cnt_d;

    assign raw = {bus.input_row4, bus.input_row3, bus.input_row2, bus.input_row1};

    // Two-flop synchronizer; reset value is all-released
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    assign pressed = ~sync2_q;

    // Key map, code 17 down to code 0; row4[1] and row4[3] are not keys
    assign hot = {pressed[19], pressed[4],  pressed[3],  pressed[17], pressed[9],  pressed[14],
                  pressed[8],  pressed[13], pressed[2],  pressed[1],  pressed[0],  pressed[7],
                  pressed[6],  pressed[5],  pressed[12], pressed[11], pressed[10], pressed[15]};
    assign unused_rows = pressed[16] ^ pressed[18];

    assign single = $onehot(hot);
    assign none   = (hot == '0);

    always_comb begin
        cur = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (hot[i]) cur = CODE_W'(i);
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            key_held_q  <= 1'b0;
            beep_q      <= 1'b0;
            beep_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_held_q  <= key_held_d;
            beep_q      <= beep_d;
            beep_cnt_q  <= beep_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        key_held_d  = key_held_q;
        beep_d      = beep_q;
        beep_cnt_d  = beep_cnt_q;

        case (state_q)
            IDLE: begin
                if (single) begin
                    cand_d  = cur;
                    cnt_d   = '0;
                    state_d = DEB_PRESS;
                end
            end
            DEB_PRESS: begin
                if (single && (cur == cand_q)) begin
                    if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        key_valid_d = 1'b1;
                        key_code_d  = cand_q;
                        key_held_d  = 1'b1;
                        state_d     = HELD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            HELD: begin
                if (none) begin
                    cnt_d   = '0;
                    state_d = DEB_REL;
                end
            end
            DEB_REL: begin
                // A bounce back to any mapped key resumes HELD without a new event
                if (none) begin
                    if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        key_held_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = HELD;
                end
            end
            default: state_d = IDLE;
        endcase

        // Buzzer: a new event always restarts a full-length click
        if (key_valid_d) begin
            beep_d     = 1'b1;
            beep_cnt_d = BEEP_W'(BEEP_CYCLES - 1);
        end else if (beep_q) begin
            if (beep_cnt_q == '0) begin
                beep_d = 1'b0;
            end else begin
                beep_cnt_d = beep_cnt_q - BEEP_W'(1);
            end
        end
    end

    assign bus.key_valid = key_valid_q;
    assign bus.key_code  = key_code_q;
    assign bus.key_held  = key_held_q;
    assign bus.beep      = beep_q;

endmodule

// File: tb/tb_key_scan_encoder.sv
// Directed bench for key_scan_encoder: a table of press patterns plus hand-written
// sequences for latency, buzzer length, multi-key release, bounce and async reset.
module tb_key_scan_encoder;

    logic clk;
    logic rst_n;

    key_scan_encoder_if bus();

    key_scan_encoder #(
        .DEBOUNCE_CYCLES(8),
        .CNT_W          (4),
        .BEEP_CYCLES    (16)
    ) dut (
        .sys_clk(clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] r1;
        logic [4:0] r2;
        logic [4:0] r3;
        logic [4:0] r4;
        int         hold;
        int         exp_pulses;
        int         exp_code;
    } vec_t;

    localparam int N_VEC = 14;
    vec_t vecs [N_VEC];

    int tests;
    int fails;
    int pulses;
    int dbl;
    logic prev_valid;

    // Count key_valid pulses and catch back-to-back highs
    initial begin
        pulses     = 0;
        dbl        = 0;
        prev_valid = 1'b0;
    end
    always @(negedge clk) begin
        if (bus.key_valid === 1'b1) begin
            pulses = pulses + 1;
            if (prev_valid) dbl = dbl + 1;
        end
        prev_valid = (bus.key_valid === 1'b1);
    end

    task automatic check(input string name, input int act, input int exp);
        tests = tests + 1;
        if (act != exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rows(input logic [4:0] r1, input logic [4:0] r2,
                            input logic [4:0] r3, input logic [4:0] r4);
        bus.input_row1 = r1;
        bus.input_row2 = r2;
        bus.input_row3 = r3;
        bus.input_row4 = r4;
    endtask

    task automatic release_all();
        set_rows(5'h1f, 5'h1f, 5'h1f, 5'h1f);
    endtask

    initial begin
        int p0;
        int beep_hi;
        tests = 0;
        fails = 0;

        //            r1        r2        r3        r4       hold pulses code
        vecs[0]  = '{5'b11110, 5'b11111, 5'b11111, 5'b11111, 20, 1,  7};
        vecs[1]  = '{5'b11111, 5'b11111, 5'b11011, 5'b11111,  5, 0,  7};
        vecs[2]  = '{5'b11111, 5'b11110, 5'b11101, 5'b11111, 20, 0,  7};
        vecs[3]  = '{5'b11111, 5'b11111, 5'b11111, 5'b10101, 20, 0,  7};
        vecs[4]  = '{5'b11111, 5'b10111, 5'b11111, 5'b10101, 20, 1, 11};
        vecs[5]  = '{5'b11111, 5'b11111, 5'b11111, 5'b01111, 20, 1, 17};
        vecs[6]  = '{5'b01111, 5'b11111, 5'b11111, 5'b11111, 20, 1, 16};
        vecs[7]  = '{5'b11111, 5'b11111, 5'b11111, 5'b11011, 20, 1, 14};
        vecs[8]  = '{5'b11111, 5'b11111, 5'b11111, 5'b11110, 20, 1,  0};
        vecs[9]  = '{5'b11111, 5'b11111, 5'b01111, 5'b11111, 20, 1, 12};
        vecs[10] = '{5'b10111, 5'b11111, 5'b11111, 5'b11111, 20, 1, 15};
        vecs[11] = '{5'b11111, 5'b11111, 5'b11011, 5'b11111,  8, 0, 15};
        vecs[12] = '{5'b11111, 5'b11111, 5'b11011, 5'b11111,  9, 1,  3};
        vecs[13] = '{5'b11111, 5'b11101, 5'b11111, 5'b11111, 20, 1,  5};

        // Reset state
        rst_n = 1'b0;
        release_all();
        tick();
        tick();
        check("reset_key_valid", int'(bus.key_valid), 0);
        check("reset_key_code",  int'(bus.key_code),  0);
        check("reset_key_held",  int'(bus.key_held),  0);
        check("reset_beep",      int'(bus.beep),      0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Table of single press/release patterns
        for (int v = 0; v < N_VEC; v++) begin
            p0 = pulses;
            set_rows(vecs[v].r1, vecs[v].r2, vecs[v].r3, vecs[v].r4);
            repeat (vecs[v].hold) tick();
            release_all();
            repeat (25) tick();
            check($sformatf("vec%0d_pulses", v), pulses - p0, vecs[v].exp_pulses);
            check($sformatf("vec%0d_code", v),   int'(bus.key_code), vecs[v].exp_code);
            check($sformatf("vec%0d_held", v),   int'(bus.key_held), 0);
            check($sformatf("vec%0d_beep", v),   int'(bus.beep), 0);
        end

        // Press latency, one-cycle pulse, buzzer length and release debounce
        beep_hi = 0;
        set_rows(5'b11110, 5'h1f, 5'h1f, 5'h1f);
        for (int k = 1; k <= 20; k++) begin
            tick();
            beep_hi += int'(bus.beep);
            if (k == 10) check("lat_valid_e10", int'(bus.key_valid), 0);
            if (k == 11) begin
                check("lat_valid_e11", int'(bus.key_valid), 1);
                check("lat_code_e11",  int'(bus.key_code),  7);
                check("lat_held_e11",  int'(bus.key_held),  1);
                check("lat_beep_e11",  int'(bus.beep),      1);
            end
            if (k == 12) check("lat_valid_e12", int'(bus.key_valid), 0);
        end
        release_all();
        for (int k = 1; k <= 25; k++) begin
            tick();
            beep_hi += int'(bus.beep);
            if (k == 9)  check("rel_held_e9",  int'(bus.key_held), 1);
            if (k == 12) check("rel_held_e12", int'(bus.key_held), 0);
        end
        check("beep_length", beep_hi, 16);

        // Two keys together, then drop one: event from the remaining key
        p0 = pulses;
        set_rows(5'h1f, 5'b11110, 5'b11101, 5'h1f);
        repeat (20) tick();
        check("dual_no_event", pulses - p0, 0);
        set_rows(5'h1f, 5'h1f, 5'b11101, 5'h1f);
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 10) check("dual_valid_e10", int'(bus.key_valid), 0);
            if (k == 11) begin
                check("dual_valid_e11", int'(bus.key_valid), 1);
                check("dual_code_e11",  int'(bus.key_code),  2);
            end
        end
        release_all();
        repeat (25) tick();
        check("dual_pulses", pulses - p0, 1);

        // Release bounce shorter than debounce: no second event
        p0 = pulses;
        set_rows(5'h1f, 5'h1f, 5'h1f, 5'b01111);
        repeat (20) tick();
        release_all();
        repeat (3) tick();
        set_rows(5'h1f, 5'h1f, 5'h1f, 5'b01111);
        repeat (20) tick();
        check("bounce_held",   int'(bus.key_held), 1);
        check("bounce_pulses", pulses - p0, 1);
        release_all();
        repeat (12) tick();
        check("bounce_released", int'(bus.key_held), 0);
        set_rows(5'h1f, 5'h1f, 5'h1f, 5'b01111);
        repeat (20) tick();
        check("repress_pulses", pulses - p0, 2);
        check("repress_code",   int'(bus.key_code), 17);
        release_all();
        repeat (25) tick();

        // Async reset mid-debounce, then restart with key still held
        set_rows(5'h1f, 5'b01111, 5'h1f, 5'h1f);
        repeat (6) tick();
        rst_n = 1'b0;
        #1;
        check("arst_key_valid", int'(bus.key_valid), 0);
        check("arst_key_code",  int'(bus.key_code),  0);
        check("arst_key_held",  int'(bus.key_held),  0);
        check("arst_beep",      int'(bus.beep),      0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 10) check("arst_valid_e10", int'(bus.key_valid), 0);
            if (k == 11) begin
                check("arst_valid_e11", int'(bus.key_valid), 1);
                check("arst_code_e11",  int'(bus.key_code),  13);
            end
        end
        release_all();
        repeat (25) tick();

        check("no_back_to_back_valid", dbl, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
